// File: rtl/disk_img_server.sv
// Sector server: moves one 512-byte sector between a requester's buffer and a
// byte-wide backing store, arbitrating between two drives.
module disk_img_server (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] sd_lba,
    input  logic [1:0]  sd_rd,
    input  logic [1:0]  sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    input  logic [7:0]  sd_buff_din,
    output logic        sd_buff_wr,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE, READ_REQ, READ_PUT, WRITE_ADDR, WRITE_LAT, WRITE_REQ, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        drive_q, drive_d;
    logic [14:0] lba_q, lba_d;
    logic        oor_q, oor_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [8:0]  buff_addr_q, buff_addr_d;
    logic [7:0]  buff_dout_q, buff_dout_d;
    logic        buff_wr_q, buff_wr_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;

    // Drive 0 wins over drive 1; within a drive, read wins over write.
    logic sel_drv, sel_rd, any_req, req_oor;
    assign any_req = |{sd_rd, sd_wr};
    assign sel_drv = ~(sd_rd[0] | sd_wr[0]);
    assign sel_rd  = sel_drv ? sd_rd[1] : sd_rd[0];
    assign req_oor = |sd_lba[31:15];

    always_comb begin
        state_d     = state_q;
        drive_d     = drive_q;
        lba_d       = lba_q;
        oor_d       = oor_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        buff_addr_d = buff_addr_q;
        buff_dout_d = buff_dout_q;
        buff_wr_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_dout_d  = mem_dout_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    drive_d = sel_drv;
                    lba_d   = sd_lba[14:0];
                    oor_d   = req_oor;
                    cnt_d   = 9'd0;
                    ack_d   = 1'b1;
                    if (sel_rd) begin
                        state_d    = READ_REQ;
                        mem_rd_d   = ~req_oor;
                        mem_addr_d = {sel_drv, sd_lba[14:0], 9'd0};
                    end else begin
                        state_d     = WRITE_ADDR;
                        buff_addr_d = 9'd0;
                    end
                end
            end
            READ_REQ: begin
                // Out-of-range sectors read as zeros without touching the store.
                if (oor_q || mem_ready) begin
                    mem_rd_d    = 1'b0;
                    buff_dout_d = oor_q ? 8'h00 : mem_din;
                    buff_addr_d = cnt_q;
                    buff_wr_d   = 1'b1;
                    state_d     = READ_PUT;
                end
            end
            READ_PUT: begin
                if (cnt_q != 9'd511) begin
                    cnt_d      = cnt_q + 9'd1;
                    mem_rd_d   = ~oor_q;
                    mem_addr_d = {drive_q, lba_q, cnt_q + 9'd1};
                    state_d    = READ_REQ;
                end else begin
                    ack_d   = 1'b0;
                    state_d = DONE;
                end
            end
            WRITE_ADDR: state_d = WRITE_LAT;
            WRITE_LAT: begin
                mem_dout_d = sd_buff_din;
                mem_wr_d   = ~oor_q;
                mem_addr_d = {drive_q, lba_q, cnt_q};
                state_d    = WRITE_REQ;
            end
            WRITE_REQ: begin
                if (oor_q || mem_ready) begin
                    mem_wr_d = 1'b0;
                    if (cnt_q != 9'd511) begin
                        cnt_d       = cnt_q + 9'd1;
                        buff_addr_d = cnt_q + 9'd1;
                        state_d     = WRITE_ADDR;
                    end else begin
                        ack_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            drive_q     <= 1'b0;
            lba_q       <= '0;
            oor_q       <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            buff_wr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            drive_q     <= drive_d;
            lba_q       <= lba_d;
            oor_q       <= oor_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            buff_addr_q <= buff_addr_d;
            buff_dout_q <= buff_dout_d;
            buff_wr_q   <= buff_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_dout_q  <= mem_dout_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_dout = buff_dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_dout     = mem_dout_q;

endmodule

// File: tb/tb_disk_img_server.sv
// Scoreboard bench for disk_img_server: stimulus pushes expected buffer puts and
// store accesses into queues, a negedge monitor pops and compares them.
module tb_disk_img_server;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic [1:0]  sd_rd = '0;
    logic [1:0]  sd_wr = '0;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din = '0;
    logic        sd_buff_wr;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ready;

    disk_img_server dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
        .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] exp_put_q[$];   // {buffer index, data}
    logic [24:0] exp_rd_q[$];    // store read address
    logic [32:0] exp_wr_q[$];    // {store address, data}

    // Stores are indexed by {drive, lba[2:0], byte}; stimulus keeps in-range lba < 8.
    logic [7:0] ref_mem [8192];
    logic [7:0] bs_mem  [8192];
    logic [7:0] wbuf    [2][512];

    int  lat = 0;
    int  wait_cnt = 0;
    bit  tie_ready = 1'b0;
    bit  no_rd = 1'b0;
    int  active_drv = 0;
    int  put_cnt = 0;

    function automatic int sidx(input logic [24:0] a);
        return int'({a[24], a[11:9], a[8:0]});
    endfunction

    assign mem_ready = tie_ready || ((mem_rd || mem_wr) && (wait_cnt >= lat));
    assign mem_din   = mem_ready ? bs_mem[sidx(mem_addr)] : 8'h00;

    always @(posedge clk_sys) begin
        if ((mem_rd || mem_wr) && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_wr && mem_ready) bs_mem[sidx(mem_addr)] <= mem_dout;
        sd_buff_din <= wbuf[active_drv][sd_buff_addr];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor
    initial begin
        logic        p_pend, p_ready, p_rd, p_wr;
        logic [24:0] p_addr;
        logic [63:0] e;
        p_pend = 0; p_ready = 0; p_rd = 0; p_wr = 0; p_addr = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                p_pend = 0;
                continue;
            end
            if (mem_rd || mem_wr) check("mem_excl", 64'(mem_rd & mem_wr), 64'd0);
            if (no_rd) check("oor_no_rd", 64'(mem_rd), 64'd0);
            if (p_pend && !p_ready)
                check("req_hold", {mem_rd, mem_wr, mem_addr}, {p_rd, p_wr, p_addr});
            if (sd_buff_wr) begin
                put_cnt++;
                if (exp_put_q.size() == 0) check("unexpected_put", 64'(sd_buff_addr), 64'h1_0000);
                else begin
                    e = 64'(exp_put_q.pop_front());
                    check("buff_put", {sd_buff_addr, sd_buff_dout}, e);
                end
            end
            if (mem_rd && mem_ready) begin
                if (exp_rd_q.size() == 0) check("unexpected_mem_rd", 64'(mem_addr), 64'h1_0000_0000);
                else begin
                    e = 64'(exp_rd_q.pop_front());
                    check("mem_rd_addr", 64'(mem_addr), e);
                end
            end
            if (mem_wr && mem_ready) begin
                if (exp_wr_q.size() == 0) check("unexpected_mem_wr", 64'(mem_addr), 64'h1_0000_0000);
                else begin
                    e = 64'(exp_wr_q.pop_front());
                    check("mem_wr", {mem_addr, mem_dout}, e);
                end
            end
            p_pend = mem_rd || mem_wr; p_ready = mem_ready;
            p_rd = mem_rd; p_wr = mem_wr; p_addr = mem_addr;
        end
    end

    // Reference model: what a sector transfer must produce.
    task automatic expect_xfer(input int drv, input bit is_rd, input logic [31:0] lba);
        logic        oor;
        logic [24:0] a;
        oor = |lba[31:15];
        for (int n = 0; n < 512; n++) begin
            a = (25'(drv) << 24) + (25'(lba[14:0]) << 9) + 25'(n);
            if (is_rd) begin
                exp_put_q.push_back({9'(n), oor ? 8'h00 : ref_mem[sidx(a)]});
                if (!oor) exp_rd_q.push_back(a);
            end else if (!oor) begin
                exp_wr_q.push_back({a, wbuf[drv][n]});
                ref_mem[sidx(a)] = wbuf[drv][n];
            end
        end
    endtask

    task automatic wait_ack(input logic val, input int limit, input string nm);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (sd_ack === val) break;
        end
        if (i == limit) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: sd_ack not %0d within %0d cycles", nm, val, limit);
        end
    endtask

    task automatic check_drained(input string nm);
        check({nm, "_puts_left"}, 64'(exp_put_q.size()), 64'd0);
        check({nm, "_rds_left"}, 64'(exp_rd_q.size()), 64'd0);
        check({nm, "_wrs_left"}, 64'(exp_wr_q.size()), 64'd0);
        exp_put_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
    endtask

    task automatic do_xfer(input int drv, input bit is_rd, input logic [31:0] lba, input string nm);
        expect_xfer(drv, is_rd, lba);
        no_rd = is_rd && (|lba[31:15]);
        @(posedge clk_sys); #1;
        active_drv = drv;
        sd_lba = lba;
        if (is_rd) sd_rd[drv] = 1'b1; else sd_wr[drv] = 1'b1;
        wait_ack(1'b1, 50, {nm, "_ack_rise"});
        sd_rd = '0; sd_wr = '0;
        wait_ack(1'b0, 6000, {nm, "_ack_fall"});
        @(negedge clk_sys);
        check({nm, "_done_ack"}, 64'(sd_ack), 64'd0);
        @(negedge clk_sys);
        no_rd = 1'b0;
        check_drained(nm);
        $display("xfer %s drv=%0d %s lba=%08h lat=%0d", nm, drv, is_rd ? "rd" : "wr", lba, lat);
    endtask

    initial begin
        logic [31:0] lba;
        int          drv, start;
        bit          rd;
        for (int i = 0; i < 8192; i++) begin
            ref_mem[i] = 8'(i);
            bs_mem[i]  = 8'(i);
        end
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 512; n++) wbuf[d][n] = 8'(n + d * 37);

        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_outputs",
              {sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_dout},
              64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Read drive 0, lba 3, store ready every cycle.
        tie_ready = 1'b1;
        do_xfer(0, 1'b1, 32'd3, "read_lba3");
        tie_ready = 1'b0;

        // Write drive 1, lba 5 with ~n, then read it back.
        for (int n = 0; n < 512; n++) wbuf[1][n] = ~8'(n);
        do_xfer(1, 1'b0, 32'd5, "write_lba5");
        do_xfer(1, 1'b1, 32'd5, "readback_lba5");

        // Both drives request a read in the same cycle.
        expect_xfer(0, 1'b1, 32'd2);
        expect_xfer(1, 1'b1, 32'd2);
        @(posedge clk_sys); #1;
        sd_lba = 32'd2; sd_rd = 2'b11;
        wait_ack(1'b1, 50, "dual_ack0");
        sd_rd = 2'b10;
        wait_ack(1'b0, 6000, "dual_fall0");
        check("dual_queue_mid", 64'(exp_put_q.size()), 64'd512);
        @(negedge clk_sys);
        check("dual_gap_ack", 64'(sd_ack), 64'd0);
        wait_ack(1'b1, 50, "dual_ack1");
        sd_rd = 2'b00;
        wait_ack(1'b0, 6000, "dual_fall1");
        repeat (2) @(negedge clk_sys);
        check_drained("dual");
        $display("xfer dual drv=0 then drv=1 rd lba=00000002");

        // Slow store: three wait cycles per access.
        lat = 3;
        do_xfer(0, 1'b1, 32'd4, "slow_read");
        do_xfer(0, 1'b0, 32'd6, "slow_write");
        lat = 0;

        // Out-of-range lba.
        do_xfer(0, 1'b1, 32'h0001_0000, "oor_read");
        do_xfer(1, 1'b0, 32'h0002_0001, "oor_write");

        // Reset during byte 100 of a read.
        lat = 1;
        expect_xfer(0, 1'b1, 32'd1);
        @(posedge clk_sys); #1;
        sd_lba = 32'd1; sd_rd = 2'b01;
        wait_ack(1'b1, 50, "rst_ack");
        sd_rd = 2'b00;
        start = put_cnt;
        for (int i = 0; i < 2000 && (put_cnt - start) < 100; i++) @(negedge clk_sys);
        check("rst_progress", 64'(put_cnt - start), 64'd100);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_dout},
              64'd0);
        exp_put_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("post_reset_idle", 64'(sd_ack), 64'd0);
        do_xfer(0, 1'b1, 32'd1, "after_reset");

        // Randomized transfers.
        for (int t = 0; t < 8; t++) begin
            drv = int'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) lba = $urandom | 32'h0000_8000;
            else lba = 32'($urandom_range(0, 7));
            if (!rd) for (int n = 0; n < 512; n++) wbuf[drv][n] = 8'($urandom);
            do_xfer(drv, rd, lba, $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
